// File: rtl/axis_hdr_insert_pkg.sv
// rtl/axis_hdr_insert_pkg.sv - shared state enum and byte-mask helpers for the header inserter
package axis_hdr_insert_pkg;

  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BODY = 2'd1,
    S_TAIL = 2'd2
  } state_e;

  function automatic int popcount(input logic [MAX_BYTES-1:0] keep);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (keep[i]) cnt++;
    end
    return cnt;
  endfunction

  // Top 'count' bits of an n-bit field; bit n-1 maps to byte 0.
  function automatic logic [MAX_BYTES-1:0] left_mask(input int count, input int n);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < n && i >= n - count) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [MAX_BYTES-1:0] right_mask(input int count);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < count) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_byte_realign.sv
// rtl/axis_byte_realign.sv - merges the low h bytes of a residue ahead of a data beat
// and extracts the next residue; shared by insert and strip style blocks.
module axis_byte_realign
  import axis_hdr_insert_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 3
) (
  input  logic [8*N-1:0] res_i,
  input  logic [8*N-1:0] data_i,
  input  logic [CNT_W-1:0] h_i,
  output logic [8*N-1:0] merged_o,
  output logic [8*N-1:0] res_next_o
);

  int         sh;
  logic [N-1:0] low_bytes;

  always_comb begin
    sh         = int'(h_i);
    low_bytes  = N'(right_mask(sh));
    merged_o   = (res_i << (8 * (N - sh))) | (data_i >> (8 * sh));
    res_next_o = '0;
    for (int j = 0; j < N; j++) begin
      res_next_o[8*j +: 8] = low_bytes[j] ? data_i[8*j +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/axis_hdr_insert_gen.sv
// rtl/axis_hdr_insert_gen.sv - prepends a 1..N byte header to each AXI-Stream packet, realigning payload.
// Optional macro: AXIS_HDR_INSERT_ZERO_HDR_EN (zero-length headers pass the payload through).
module axis_hdr_insert_gen
  import axis_hdr_insert_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      header_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  output logic                    ready_insert
);

  localparam int N     = DATA_BYTE_WD;
  localparam int CNT_W = $clog2(N + 1);

  state_e             state_q, state_d;
  logic [DATA_WD-1:0] res_q, res_d;
  logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0]   h_q, h_d;
  logic               valid_q, valid_d;
  logic [DATA_WD-1:0] data_q, data_d;
  logic [N-1:0]       keep_q, keep_d;
  logic               last_q, last_d;

  logic               load, hdr_take, ready_insert_c;
  logic [CNT_W-1:0]   h_ins;
  logic [DATA_WD-1:0] align_data, merged, res_next, out_data;
  logic [N-1:0]       out_keep;
  logic               out_last, emit;
  int                 m_cnt, sum_cnt;

  assign load  = ~valid_q | ready_out;
  assign h_ins = CNT_W'(popcount(MAX_BYTES'(keep_insert)));

`ifdef AXIS_HDR_INSERT_ZERO_HDR_EN
  assign hdr_take = valid_insert;
`else
  assign hdr_take = valid_insert & (h_ins != '0);
`endif

  // In the tail the residue is flushed on its own, so the data lane is zeroed.
  assign align_data = (state_q == S_TAIL) ? '0 : data_in;

  axis_byte_realign #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_realign (
    .res_i      (res_q),
    .data_i     (align_data),
    .h_i        (h_q),
    .merged_o   (merged),
    .res_next_o (res_next)
  );

  always_comb begin
    state_d        = state_q;
    res_d          = res_q;
    res_cnt_d      = res_cnt_q;
    h_d            = h_q;
    valid_d        = valid_q;
    data_d         = data_q;
    keep_d         = keep_q;
    last_d         = last_q;
    ready_in       = 1'b0;
    ready_insert_c = 1'b0;
    out_data       = merged;
    out_keep       = '0;
    out_last       = 1'b0;
    emit           = 1'b0;
    m_cnt          = popcount(MAX_BYTES'(keep_in));
    sum_cnt        = int'(h_q) + m_cnt;

    if (load) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_insert_c = 1'b1;
        if (hdr_take) begin
          res_d     = header_insert;
          res_cnt_d = h_ins;
          h_d       = h_ins;
          state_d   = S_BODY;
        end
      end
      S_BODY: begin
        ready_in = load;
        if (valid_in && load) begin
          emit  = 1'b1;
          res_d = res_next;
          if (!last_in) begin
            out_keep = '1;
          end else if (sum_cnt <= N) begin
            out_keep = N'(left_mask(sum_cnt, N));
            out_last = 1'b1;
            state_d  = S_IDLE;
          end else begin
            out_keep  = '1;
            res_cnt_d = CNT_W'(sum_cnt - N);
            state_d   = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        if (load) begin
          emit     = 1'b1;
          out_keep = N'(left_mask(int'(res_cnt_q), N));
          out_last = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bytes outside keep are zeroed so the output never leaks stale residue.
    if (emit) begin
      valid_d = 1'b1;
      keep_d  = out_keep;
      last_d  = out_last;
      for (int j = 0; j < N; j++) begin
        data_d[8*j +: 8] = out_keep[j] ? out_data[8*j +: 8] : 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      res_q     <= '0;
      res_cnt_q <= '0;
      h_q       <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      keep_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      res_cnt_q <= res_cnt_d;
      h_q       <= h_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      keep_q    <= keep_d;
      last_q    <= last_d;
    end
  end

  assign valid_out    = valid_q;
  assign data_out     = data_q;
  assign keep_out     = keep_q;
  assign last_out     = last_q;
  assign ready_insert = ready_insert_c & rst_n;

endmodule

// File: doc/axis_hdr_insert_gen.md
Name: axis_hdr_insert_gen

Overview:
Parametrised successor to the fixed 32-bit header inserter. It prepends a variable-length header (1..DATA_BYTE_WD bytes) to each AXI-Stream packet and realigns the payload so the output carries no gap bytes. It uses full valid/ready backpressure on all three interfaces and emits an extra tail beat when the realigned residue spills. It sits between the packet source and the framing/egress stage.

Parameters:
DATA_WD, 32, data bus width in bits; multiple of 8, at least 16.
DATA_BYTE_WD, DATA_WD/8, bytes per beat (N).

Ports:
clk  in  1  clock.
rst_n  in  1  reset; asynchronous assert, active-low.
valid_in  in  1  payload beat valid.
data_in  in  DATA_WD  payload; byte 0 = data_in[DATA_WD-1 -: 8].
keep_in  in  N  byte enables; all ones except on the last beat, where they are left-aligned contiguous.
last_in  in  1  last payload beat.
ready_in  out  1  payload accept.
valid_out  out  1  output beat valid.
data_out  out  DATA_WD  realigned output.
keep_out  out  N  left-aligned contiguous byte enables.
last_out  out  1  last output beat.
ready_out  in  1  downstream accept.
valid_insert  in  1  header valid.
header_insert  in  DATA_WD  header; valid bytes in the low-order positions.
keep_insert  in  N  right-aligned contiguous enables; H = popcount.
ready_insert  out  1  header accept.

Behaviour:
- Reset values: all outputs 0, state S_IDLE, residue register 0. An asserted reset mid-packet drops the packet; nothing is replayed.
- Output register: a single register stage. load = ~valid_out | ready_out. Holding rule: data_out, keep_out and last_out stay stable while valid_out=1 and ready_out=0.
- Residue register: res (N bytes) plus res_cnt (width $clog2(N+1)).
- S_IDLE:
  - ready_insert=1, ready_in=0.
  - On a header handshake with H>0: res <= header_insert, res_cnt <= H, go to S_BODY.
- S_BODY:
  - ready_in = load. ready_insert=0.
  - On each accepted beat with m = popcount(keep_in):
    - out = {low H bytes of res, top N-H bytes of data_in}.
    - res <= low H bytes of data_in.
  - Non-last beat: keep_out = all ones.
  - Last beat with H+m <= N: keep_out = top (H+m) ones, last_out=1, go to S_IDLE.
  - Last beat with H+m > N: keep_out = all ones, last_out=0, res_cnt <= H+m-N, go to S_TAIL.
  - H==N degenerates naturally: the header goes out alone on the first beat, and every last beat enters S_TAIL.
- S_TAIL:
  - ready_in=0, ready_insert=0.
  - When load=1: emit res top-justified, keep_out = top res_cnt ones, last_out=1, go to S_IDLE.
- Latency: the first output beat appears 1 cycle after the first payload handshake. Throughput is 1 beat/clk with ready_out held high, plus 1 extra beat per spilling packet.
- Simultaneous events:
  - A header offered during S_BODY/S_TAIL waits; ready_insert rises the cycle after the packet ends.
  - Payload offered before a header is stalled (ready_in=0).
- Back-to-back packets: one idle cycle on ready_in per packet boundary (the header accept cycle).

Optional Feature:
Macro: AXIS_HDR_INSERT_ZERO_HDR_EN.
- Defined: keep_insert==0 is legal (H=0). The packet passes unmodified through S_BODY, and S_TAIL is never entered.
- Undefined: a header with keep_insert==0 is accepted, discarded, and the block stays in S_IDLE.

Decomposition:
- Package axis_hdr_insert_pkg: state enum (S_IDLE, S_BODY, S_TAIL); functions popcount(keep), left_mask(count), right_mask(count); localparam CNT_W = $clog2(N+1).
- Sub-module axis_byte_realign: combinational merge of res/data by H and next-residue extraction, reusable by a future header-strip block.

Test Plan:
1. DATA_WD=32, H=2 (keep_insert=0011, header 0xxxxxAABB), 2-beat payload 11223344 and 55667788 with last keep=1111 -> out AABB1122, 33445566, 7788xxxx; keeps 1111, 1111, 1100; last_out on beat 3.
2. H=3 (0111, header xxAABBCC), single beat 11223344 with keep=1000 -> single beat AABBCC11, keep 1111, last_out=1; no tail.
3. H=4 (header DEADBEEF), one beat 01020304 keep=1100 -> DEADBEEF/1111, then 0102xxxx/1100/last.
4. Backpressure: scenario 1 with ready_out toggling 1,0,0,1 and random valid_in gaps -> identical output sequence, no drops or duplicates, outputs stable while stalled.
5. Back-to-back packets, second header offered during the first packet's S_TAIL -> ready_insert=0 until the tail handshake, then 1 on the next cycle; the second packet is correct.
6. rst_n pulsed low mid-S_BODY -> all outputs 0 immediately; the next header+packet is processed cleanly. With the macro defined, keep_insert=0000 passes the payload unchanged.
